// File: rtl/note_scheduler_pkg.sv
// Shared definitions for the note scheduler.
//   - Chart ROM word layout: {hit_ms[HIT_W-1:0], lane_mask[LANES-1:0]}.
//     An all-zero lane_mask marks the end of the chart.
//   - Default timing parameters (50 MHz clock, 2 s scroll lead).
//   - FSM state encoding.
package note_scheduler_pkg;

  localparam int HIT_W               = 16;
  localparam int LANES_DEFAULT       = 4;
  localparam int ADDR_W_DEFAULT      = 8;
  localparam int CLKS_PER_MS_DEFAULT = 50000;
  localparam int LEAD_MS_DEFAULT     = 2000;

  // lane_mask sits in the low bits of a chart word, hit_ms directly above it
  localparam int MASK_LSB = 0;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LATCH = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_EMIT  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_FETCH = ST_FETCH,
    S_LATCH = ST_LATCH,
    S_WAIT  = ST_WAIT,
    S_EMIT  = ST_EMIT,
    S_DONE  = ST_DONE
  } state_e;

endpackage

// File: rtl/note_scheduler_ms_timebase.sv
// ms_timebase: millisecond song clock.
//   clock, reset : system clock, asynchronous active-high reset
//   run          : advance the prescaler (low = hold, e.g. paused)
//   clear        : synchronous clear of prescaler and song_ms (wins over run)
//   song_ms      : elapsed song milliseconds, saturating at 16'hFFFF
module ms_timebase #(
  parameter int CLKS_PER_MS = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        clear,
  output logic [15:0] song_ms
);

  localparam int PRE_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLKS_PER_MS - 1);

  logic [PRE_W-1:0] pre_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_q   <= '0;
      song_ms <= '0;
    end else if (clear) begin
      pre_q   <= '0;
      song_ms <= '0;
    end else if (run) begin
      if (pre_q == PRE_MAX) begin
        pre_q <= '0;
        if (song_ms != 16'hFFFF) begin
          song_ms <= song_ms + 16'd1;
        end
      end else begin
        pre_q <= pre_q + PRE_W'(1);
      end
    end
  end

endmodule

// File: rtl/note_scheduler.sv
// note_scheduler: walks the chart ROM in order and offers each note to the
// renderer LEAD_MS before its hit time.
//   clock, reset      : system clock, asynchronous active-high reset
//   game_active       : high while playing (stays high through pause)
//   show_pause_screen : freezes song time and scheduling
//   chart_addr        : ROM address; chart_data is valid one cycle later
//   chart_data        : {hit_ms[15:0], lane_mask[LANES-1:0]}, mask 0 = end
//   spawn_*           : note offer to the renderer
//   song_ms           : current song time
//   chart_done        : terminator reached (or last address consumed)
//
// Spawn handshake: spawn_valid is raised in EMIT and, together with
// spawn_lanes/spawn_hit_ms, stays stable until the cycle where spawn_valid
// and spawn_ready are both high; that cycle is the single transfer. The
// offer is masked in the cycle game_active falls, so that cycle never
// transfers. Pausing does not withdraw an offer.
module note_scheduler
  import note_scheduler_pkg::*;
#(
  parameter int CLKS_PER_MS = CLKS_PER_MS_DEFAULT,
  parameter int LEAD_MS     = LEAD_MS_DEFAULT,
  parameter int ADDR_W      = ADDR_W_DEFAULT,
  parameter int LANES       = LANES_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   game_active,
  input  logic                   show_pause_screen,
  output logic [ADDR_W-1:0]      chart_addr,
  input  logic [HIT_W+LANES-1:0] chart_data,
  output logic                   spawn_valid,
  input  logic                   spawn_ready,
  output logic [LANES-1:0]       spawn_lanes,
  output logic [HIT_W-1:0]       spawn_hit_ms,
  output logic [15:0]            song_ms,
  output logic                   chart_done
);

  localparam int WORD_W = HIT_W + LANES;

  state_e              state_q, state_d;
  logic                ga_q;
  logic                run, rise, fall, xfer, due, latch_en;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [HIT_W-1:0]    hit_q;
  logic [LANES-1:0]    lanes_q;
  logic [HIT_W:0]      horizon;
  logic [LANES-1:0]    rom_mask;
  logic [HIT_W-1:0]    rom_hit;

  assign run  = game_active & ~show_pause_screen;
  assign rise = game_active & ~ga_q;
  assign fall = ga_q & ~game_active;

  assign rom_mask = chart_data[MASK_LSB +: LANES];
  assign rom_hit  = chart_data[WORD_W-1 -: HIT_W];

  // 17-bit compare: song_ms + LEAD_MS cannot wrap
  assign horizon = {1'b0, song_ms} + (HIT_W+1)'(LEAD_MS);
  assign due     = run & (horizon >= {1'b0, hit_q});

  assign spawn_valid  = (state_q == S_EMIT) & game_active;
  assign xfer         = spawn_valid & spawn_ready;
  assign spawn_lanes  = lanes_q;
  assign spawn_hit_ms = hit_q;
  assign chart_addr   = addr_q;
  assign chart_done   = (state_q == S_DONE);

  ms_timebase #(
    .CLKS_PER_MS (CLKS_PER_MS)
  ) u_timebase (
    .clock   (clock),
    .reset   (reset),
    .run     (run),
    .clear   (fall),
    .song_ms (song_ms)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    latch_en = 1'b0;
    if (fall) begin
      // song end or restart overrides whatever the FSM was doing
      state_d = S_IDLE;
      addr_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          addr_d = '0;
          if (rise) state_d = S_FETCH;
        end
        S_FETCH: state_d = S_LATCH;
        S_LATCH: begin
          latch_en = 1'b1;
          state_d  = (rom_mask == '0) ? S_DONE : S_WAIT;
        end
        S_WAIT: begin
          if (due) state_d = S_EMIT;
        end
        S_EMIT: begin
          if (xfer) begin
            // the last ROM address ends the chart rather than wrapping to 0
            if (&addr_q) begin
              state_d = S_DONE;
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = S_FETCH;
            end
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ga_q    <= 1'b0;
      addr_q  <= '0;
      hit_q   <= '0;
      lanes_q <= '0;
    end else begin
      state_q <= state_d;
      ga_q    <= game_active;
      addr_q  <= addr_d;
      if (latch_en) begin
        hit_q   <= rom_hit;
        lanes_q <= rom_mask;
      end
    end
  end

endmodule

// File: tb/tb_note_scheduler.sv
module tb_note_scheduler;

  localparam int CLKS_PER_MS = 8;
  localparam int LEAD_MS     = 2000;
  localparam int ADDR_W      = 8;
  localparam int LANES       = 4;
  localparam int WORD_W      = 16 + LANES;

  logic              clock = 1'b0;
  logic              reset;
  logic              game_active;
  logic              show_pause_screen;
  logic [ADDR_W-1:0] chart_addr;
  logic [WORD_W-1:0] chart_data;
  logic              spawn_valid;
  logic              spawn_ready;
  logic [LANES-1:0]  spawn_lanes;
  logic [15:0]       spawn_hit_ms;
  logic [15:0]       song_ms;
  logic              chart_done;

  note_scheduler #(
    .CLKS_PER_MS (CLKS_PER_MS),
    .LEAD_MS     (LEAD_MS),
    .ADDR_W      (ADDR_W),
    .LANES       (LANES)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .game_active       (game_active),
    .show_pause_screen (show_pause_screen),
    .chart_addr        (chart_addr),
    .chart_data        (chart_data),
    .spawn_valid       (spawn_valid),
    .spawn_ready       (spawn_ready),
    .spawn_lanes       (spawn_lanes),
    .spawn_hit_ms      (spawn_hit_ms),
    .song_ms           (song_ms),
    .chart_done        (chart_done)
  );

  // ---------------- clock / chart ROM ----------------
  always #5 clock = ~clock;

  logic [WORD_W-1:0] rom [256];
  always @(posedge clock) chart_data <= rom[chart_addr];

  // ---------------- scoreboard state ----------------
  logic [WORD_W-1:0] exp_q[$];
  int                xfer_ms_q[$];
  int                n_xfer;
  int                n_tests;
  int                n_fail;
  logic              prev_pending;
  logic [WORD_W-1:0] prev_word;

  function automatic int exp_spawn_ms(input int hit);
    return (hit > LEAD_MS) ? hit - LEAD_MS : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Observe the handshake mid-cycle, then advance to just after the next edge.
  task automatic tick;
    logic [WORD_W-1:0] w;
    logic [WORD_W-1:0] e;
    @(negedge clock);
    if (!reset && game_active) begin
      w = {spawn_hit_ms, spawn_lanes};
      if (prev_pending) begin
        check("hold_valid", 32'(spawn_valid), 32'd1);
        check("hold_payload", 32'(w), 32'(prev_word));
      end
      if (spawn_valid && spawn_ready) begin
        n_xfer++;
        xfer_ms_q.push_back(int'(song_ms));
        check("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("xfer_payload", 32'(w), 32'(e));
          check("not_early", 32'((int'(song_ms) + LEAD_MS) >= int'(e[WORD_W-1 -: 16])), 32'd1);
        end
      end
      prev_pending = spawn_valid && !spawn_ready;
      prev_word    = w;
    end else begin
      prev_pending = 1'b0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load_entry(input int idx, input int hit, input int lanes);
    rom[idx] = {16'(hit), 4'(lanes)};
  endtask

  task automatic clear_rom;
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  // Drop game_active, confirm the cleared state, reset the scoreboard.
  task automatic end_game;
    game_active = 1'b0;
    tick();
    check("end_song_ms", 32'(song_ms), 32'd0);
    check("end_addr", 32'(chart_addr), 32'd0);
    check("end_done", 32'(chart_done), 32'd0);
    check("end_valid", 32'(spawn_valid), 32'd0);
    tick();
    exp_q.delete();
    xfer_ms_q.delete();
    n_xfer = 0;
  endtask

  // Expected spawn order is simply the chart up to its terminator.
  task automatic start_game;
    for (int i = 0; i < 256; i++) begin
      if (rom[i][LANES-1:0] == '0) break;
      exp_q.push_back(rom[i]);
    end
    game_active = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    int n = 0;
    while (!chart_done && n < max_cycles) begin tick(); n++; end
    check(tag, 32'(chart_done), 32'd1);
  endtask

  task automatic wait_valid(input string tag, input int max_cycles);
    int n = 0;
    while (!spawn_valid && n < max_cycles) begin tick(); n++; end
    check(tag, 32'(spawn_valid), 32'd1);
  endtask

  task automatic wait_ms(input string tag, input int target, input int max_cycles);
    int n = 0;
    while (int'(song_ms) < target && n < max_cycles) begin tick(); n++; end
    check(tag, 32'(song_ms), 32'(target));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    int h;
    n_tests = 0; n_fail = 0; n_xfer = 0; prev_pending = 1'b0; prev_word = '0;
    clear_rom();
    reset = 1'b1; game_active = 1'b0; show_pause_screen = 1'b0; spawn_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_addr", 32'(chart_addr), 32'd0);
    check("rst_valid", 32'(spawn_valid), 32'd0);
    check("rst_song_ms", 32'(song_ms), 32'd0);
    check("rst_done", 32'(chart_done), 32'd0);
    check("rst_lanes", 32'(spawn_lanes), 32'd0);
    check("rst_hit", 32'(spawn_hit_ms), 32'd0);
    reset = 1'b0;
    tick();

    // Basic spawn timing
    load_entry(0, 1000, 4'b0001); load_entry(1, 2500, 4'b0100); load_entry(2, 0, 0);
    spawn_ready = 1'b1;
    start_game();
    wait_done("basic_done", 5000);
    check("basic_count", 32'(n_xfer), 32'd2);
    check("basic_ms0", 32'(xfer_ms_q[0]), 32'(exp_spawn_ms(1000)));
    check("basic_ms1", 32'(xfer_ms_q[1]), 32'(exp_spawn_ms(2500)));
    check("basic_valid_done", 32'(spawn_valid), 32'd0);
    end_game();

    // Pause at 300 ms for 10 ms
    start_game();
    wait_ms("pause_reach", 300, 4000);
    show_pause_screen = 1'b1;
    ticks(10 * CLKS_PER_MS);
    check("pause_song_ms", 32'(song_ms), 32'd300);
    check("pause_xfers", 32'(n_xfer), 32'd1);
    show_pause_screen = 1'b0;
    wait_done("pause_done", 5000);
    check("pause_ms1", 32'(xfer_ms_q[1]), 32'd500);
    end_game();

    // Restart while waiting at 700 ms; first note must come back
    clear_rom();
    load_entry(0, 1000, 4'b0001); load_entry(1, 5000, 4'b1000);
    start_game();
    wait_ms("restart_reach", 700, 7000);
    check("restart_valid_wait", 32'(spawn_valid), 32'd0);
    check("restart_xfers", 32'(n_xfer), 32'd1);
    end_game();
    start_game();
    wait_valid("restart_reoffer", 20);
    check("restart_addr", 32'(chart_addr), 32'd0);
    tick();
    check("restart_reemit", 32'(n_xfer), 32'd1);
    end_game();

    // Backpressure: 100-cycle stall, then next offer 3 cycles after transfer
    clear_rom();
    load_entry(0, 0, 4'b0001); load_entry(1, 0, 4'b0010); load_entry(2, 0, 4'b0100);
    spawn_ready = 1'b0;
    start_game();
    wait_valid("bp_offer", 20);
    ticks(100);
    check("bp_no_xfer", 32'(n_xfer), 32'd0);
    spawn_ready = 1'b1;
    tick();
    spawn_ready = 1'b0;
    check("bp_one_xfer", 32'(n_xfer), 32'd1);
    n = 0;
    while (!spawn_valid && n < 20) begin tick(); n++; end
    check("bp_latency", 32'(n), 32'd3);
    spawn_ready = 1'b1;
    wait_done("bp_done", 50);
    check("bp_count", 32'(n_xfer), 32'd3);
    end_game();

    // Random chart, random ready and pauses
    clear_rom();
    h = $urandom_range(0, 300);
    for (int i = 0; i < 16; i++) begin
      load_entry(i, h, $urandom_range(1, 15));
      h += $urandom_range(0, 120);
    end
    start_game();
    n = 0;
    while (!chart_done && n < 20000) begin
      spawn_ready       = ($urandom_range(0, 3) != 0);
      show_pause_screen = ($urandom_range(0, 15) == 0);
      tick();
      n++;
    end
    show_pause_screen = 1'b0;
    spawn_ready       = 1'b1;
    check("rand_done", 32'(chart_done), 32'd1);
    check("rand_count", 32'(n_xfer), 32'd16);
    check("rand_sb_empty", 32'(exp_q.size()), 32'd0);
    end_game();

    // Full ROM: 256 entries, no wrap
    for (int i = 0; i < 256; i++) load_entry(i, 0, (i % 15) + 1);
    start_game();
    wait_done("full_done", 3000);
    check("full_count", 32'(n_xfer), 32'd256);
    check("full_addr", 32'(chart_addr), 32'd255);
    ticks(5);
    check("full_addr_hold", 32'(chart_addr), 32'd255);
    check("full_valid", 32'(spawn_valid), 32'd0);
    end_game();

    // Asynchronous reset while an offer is pending
    clear_rom();
    load_entry(0, 0, 4'b0001); load_entry(1, 0, 4'b0010);
    spawn_ready = 1'b0;
    start_game();
    wait_valid("ar_offer0", 20);
    n = 0;
    while (song_ms < 16'd3 && n < 100) begin tick(); n++; end
    spawn_ready = 1'b1;
    tick();
    spawn_ready = 1'b0;
    wait_valid("ar_offer1", 20);
    check("ar_pre_addr", 32'(chart_addr), 32'd1);
    check("ar_pre_ms", 32'(song_ms != 16'd0), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_valid", 32'(spawn_valid), 32'd0);
    check("ar_addr", 32'(chart_addr), 32'd0);
    check("ar_song_ms", 32'(song_ms), 32'd0);
    check("ar_done", 32'(chart_done), 32'd0);
    ticks(2);
    game_active = 1'b0;
    reset = 1'b0;
    ticks(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
